moving_average2_inverse: RTL and testbench

MOVING_AVERAGE2_INVERSE -- requirements
Module: moving_average2_inverse

---
 rtl/moving_average2_pkg.sv | 13 +
 rtl/moving_average2_delay_line.sv | 31 +++
 rtl/moving_average2_inverse.sv | 98 +++++++++
 tb/tb_moving_average2_inverse.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/moving_average2_pkg.sv
// Shared defaults and state encoding for the moving-sum inverse (sample recovery) block.
package moving_average2_pkg;

  localparam int DW_DEF  = 8;
  localparam int WIN_DEF = 4;
  localparam int SW_DEF  = DW_DEF + $clog2(WIN_DEF);

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

endpackage

// File: rtl/moving_average2_delay_line.sv
// WIN-deep shift register holding recovered samples; dout is the sample from WIN accepts ago.
module moving_average2_delay_line
  import moving_average2_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int WIN = WIN_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic signed [DW-1:0] din,
  output logic signed [DW-1:0] dout
);

  logic signed [DW-1:0] taps [WIN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN; i++) taps[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < WIN; i++) taps[i] <= '0;
    end else if (en) begin
      taps[0] <= din;
      for (int i = 1; i < WIN; i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = taps[WIN-1];

endmodule

// File: rtl/moving_average2_inverse.sv
// Recovers x[n] from a WIN-sample moving sum: x[n] = s[n] - s[n-1] + x[n-WIN], saturated to DW bits.
module moving_average2_inverse
  import moving_average2_pkg::*;
#(
  parameter  int DW  = DW_DEF,
  parameter  int WIN = WIN_DEF,
  localparam int SW  = DW + $clog2(WIN)
) (
  input  logic                 system1000,
  input  logic                 system1000_rstn,
  input  logic signed [SW-1:0] sum_i,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 clr,
  output logic signed [DW-1:0] sample_o,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err_o
);

  // True when the SW+2-bit difference does not fit in DW signed bits.
  function automatic logic x_ovf(input logic signed [SW+1:0] v);
    return !((&v[SW+1:DW-1]) || !(|v[SW+1:DW-1]));
  endfunction

  function automatic logic signed [DW-1:0] x_sat(input logic signed [SW+1:0] v);
    if (!x_ovf(v))  return v[DW-1:0];
    else if (v[SW+1]) return {1'b1, {(DW-1){1'b0}}};
    else            return {1'b0, {(DW-1){1'b1}}};
  endfunction

  state_t               state_q, state_d;
  logic signed [SW-1:0] s_prev_p1;
  logic signed [DW-1:0] sample_p1;
  logic                 vld_p1;
  logic signed [DW-1:0] hist_out;
  logic signed [SW+1:0] sum_ext, prev_ext, hist_ext, x_full_p0;
  logic signed [DW-1:0] x_sat_p0;
  logic                 ovf_p0;
  logic                 accept;

  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready && !clr;

  // Stage p0: combinational recovery from the current sum and stored history.
  assign sum_ext   = {{2{sum_i[SW-1]}}, sum_i};
  assign prev_ext  = {{2{s_prev_p1[SW-1]}}, s_prev_p1};
  assign hist_ext  = {{(SW+2-DW){hist_out[DW-1]}}, hist_out};
  assign x_full_p0 = sum_ext - prev_ext + hist_ext;
  assign x_sat_p0  = x_sat(x_full_p0);
  assign ovf_p0    = x_ovf(x_full_p0);

  moving_average2_delay_line #(
    .DW  (DW),
    .WIN (WIN)
  ) u_hist (
    .clk   (system1000),
    .rst_n (system1000_rstn),
    .en    (accept),
    .clr   (clr),
    .din   (x_sat_p0),
    .dout  (hist_out)
  );

  always_comb begin
    state_d = state_q;
    if (clr)                 state_d = RUN;
    else if (accept && ovf_p0) state_d = FAULT;
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) state_q <= RUN;
    else                  state_q <= state_d;
  end

  // Stage p1: output register and previous-sum register.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      vld_p1    <= 1'b0;
      sample_p1 <= '0;
      s_prev_p1 <= '0;
    end else if (clr) begin
      vld_p1    <= 1'b0;
      s_prev_p1 <= '0;
    end else if (accept) begin
      vld_p1    <= 1'b1;
      sample_p1 <= x_sat_p0;
      s_prev_p1 <= sum_i;
    end else if (out_ready) begin
      vld_p1    <= 1'b0;
    end
  end

  assign sample_o  = sample_p1;
  assign out_valid = vld_p1;
  assign err_o     = (state_q == FAULT);

endmodule

// File: tb/tb_moving_average2_inverse.sv
// Directed bench for moving_average2_inverse (DW=8, WIN=4) with hand-computed expectations.
module tb_moving_average2_inverse;

  logic              system1000 = 1'b0;
  logic              system1000_rstn;
  logic signed [9:0] sum_i;
  logic              in_valid;
  logic              in_ready;
  logic              clr;
  logic signed [7:0] sample_o;
  logic              out_valid;
  logic              out_ready;
  logic              err_o;

  int n_cmp = 0;
  int n_err = 0;

  moving_average2_inverse dut (
    .system1000      (system1000),
    .system1000_rstn (system1000_rstn),
    .sum_i           (sum_i),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .clr             (clr),
    .sample_o        (sample_o),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .err_o           (err_o)
  );

  always #5 system1000 = ~system1000;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge system1000);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1; in_valid = 1'b0;
    step();
    clr = 1'b0;
  endtask

  task automatic push(input int s, input int exp, input string tag);
    sum_i = 10'(s); in_valid = 1'b1;
    step();
    check({tag, "_vld"}, int'(out_valid), 1);
    check({tag, "_x"}, int'(sample_o), exp);
  endtask

  int sums_a [5] = '{1, 3, 6, 10, 14};
  int exp_a  [5] = '{1, 2, 3, 4, 5};
  int sums_b [5] = '{-128, -256, -384, -512, -512};

  initial begin
    system1000_rstn = 1'b0;
    sum_i = '0; in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_ready", int'(in_ready), 1);
    check("rst_vld", int'(out_valid), 0);
    check("rst_x", int'(sample_o), 0);
    check("rst_err", int'(err_o), 0);
    #2 system1000_rstn = 1'b1;
    step();
    check("post_rst_ready", int'(in_ready), 1);

    // Ramp: one new sample per accept.
    for (int i = 0; i < 5; i++) push(sums_a[i], exp_a[i], $sformatf("ramp%0d", i));
    in_valid = 1'b0;
    step();
    check("ramp_drain_vld", int'(out_valid), 0);

    // Constant negative samples at the lower bound, no saturation.
    do_clr();
    for (int i = 0; i < 5; i++) begin
      push(sums_b[i], -128, $sformatf("neg%0d", i));
      check($sformatf("neg%0d_err", i), int'(err_o), 0);
    end
    in_valid = 1'b0;
    step();

    // Backpressure: hold for 3 cycles, then drain and accept together.
    do_clr();
    out_ready = 1'b0;
    push(1, 1, "bp0");
    sum_i = 10'sd3; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_hold%0d_ready", i), int'(in_ready), 0);
      step();
      check($sformatf("bp_hold%0d_x", i), int'(sample_o), 1);
      check($sformatf("bp_hold%0d_vld", i), int'(out_valid), 1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", int'(in_ready), 1);
    step();
    check("bp1_vld", int'(out_valid), 1);
    check("bp1_x", int'(sample_o), 2);
    push(6, 3, "bp2");
    in_valid = 1'b0;
    step();
    check("bp_drain_vld", int'(out_valid), 0);

    // Positive overflow saturates and latches FAULT until clr.
    do_clr();
    push(0, 0, "sat0");
    check("sat0_err", int'(err_o), 0);
    push(300, 127, "sat1");
    check("sat1_err", int'(err_o), 1);
    push(300, 0, "sat2");
    check("sat2_err", int'(err_o), 1);
    in_valid = 1'b0;
    step(); step();
    check("sat_idle_err", int'(err_o), 1);
    do_clr();
    check("sat_clr_err", int'(err_o), 0);
    check("sat_clr_vld", int'(out_valid), 0);

    // Mid-stream reset discards history.
    push(1, 1, "mr0");
    push(3, 2, "mr1");
    in_valid = 1'b0;
    #2 system1000_rstn = 1'b0;
    #1;
    check("mr_rst_vld", int'(out_valid), 0);
    check("mr_rst_ready", int'(in_ready), 1);
    #2 system1000_rstn = 1'b1;
    step();
    push(5, 5, "mr2");

    // clr in the same cycle as a valid input drops that input.
    do_clr();
    push(4, 4, "cv0");
    sum_i = 10'sd9; in_valid = 1'b1; clr = 1'b1;
    step();
    clr = 1'b0;
    check("cv_drop_vld", int'(out_valid), 0);
    push(2, 2, "cv1");
    in_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
